// File: rtl/alu_pkg.sv
// Shared opcodes, B-source selects and FSM state encoding for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_NAND = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_XNOR = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;
  localparam logic [3:0] OP_PASS = 4'd12;
  localparam logic [3:0] OP_CLR  = 4'd13;

  localparam logic [1:0] BSEL_B    = 2'd0;
  localparam logic [1:0] BSEL_ACC  = 2'd1;
  localparam logic [1:0] BSEL_ZERO = 2'd2;
  localparam logic [1:0] BSEL_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_iter(input logic [3:0] op_code);
    return (op_code == OP_MUL) || (op_code == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier and restoring divider sharing one 2*WIDTH shift register.
module alu_muldiv_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_init;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   m_src;
  logic               div_q;
  logic               dz;
  logic [CW-1:0]      cnt;

  // MUL: p = {partial product, remaining multiplier bits}, m = multiplicand.
  // DIV: p = {partial remainder, dividend bits -> quotient bits}, m = divisor.
  function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] pv,
                                              input logic [WIDTH-1:0]   mv,
                                              input logic               dv);
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] r;
    sum   = '0;
    trial = '0;
    if (dv) begin
      trial = pv[2*WIDTH-1:WIDTH-1] - {1'b0, mv};
      if (!trial[WIDTH]) r = {trial[WIDTH-1:0], pv[WIDTH-2:0], 1'b1};
      else               r = {pv[2*WIDTH-2:0], 1'b0};
    end else begin
      sum = {1'b0, pv[2*WIDTH-1:WIDTH]} + (pv[0] ? {1'b0, mv} : '0);
      r   = {sum, pv[WIDTH-1:1]};
    end
    return r;
  endfunction

  always_comb begin
    p_init = is_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
    m_src  = is_div ? b : a;
  end

  // The first iteration happens on the load edge so WIDTH steps finish WIDTH-1 edges later.
  always_ff @(posedge clk) begin
    if (rst) begin
      p     <= '0;
      m     <= '0;
      div_q <= 1'b0;
      dz    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        p     <= step(p_init, m_src, is_div);
        m     <= m_src;
        div_q <= is_div;
        dz    <= is_div && (b == '0);
        cnt   <= CW'(1);
        busy  <= 1'b1;
      end else if (busy) begin
        p   <= step(p, m, div_q);
        cnt <= cnt + CW'(1);
        if (cnt == LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign result = p[WIDTH-1:0];
  assign flag   = div_q ? dz : (|p[2*WIDTH-1:WIDTH]);

endmodule

// File: rtl/alu_acc_seq.sv
// Sequential ALU with accumulator: valid/ready command in, registered result and flags out.
module alu_acc_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [1:0]       b_sel,
  input  logic             acc_we,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_v,
  output logic [WIDTH-1:0] acc
);

  localparam int SHW = $clog2(WIDTH) + 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends on valid, and the producer holds its payload until the transfer.
  state_t           state;
  logic             we_q;
  logic [WIDTH-1:0] b_val;
  logic [WIDTH-1:0] sc_result;
  logic             sc_carry;
  logic [WIDTH:0]   sum_w;
  logic [SHW-1:0]   shamt;
  logic             shamt_big;
  logic             md_start;
  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic             md_flag;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign md_start  = in_valid && in_ready && is_iter(op) && !md_busy;

  always_comb begin
    case (b_sel)
      BSEL_B:   b_val = b_in;
      BSEL_ACC: b_val = acc;
      default:  b_val = '0;
    endcase
  end

  assign shamt     = b_val[SHW-1:0];
  assign shamt_big = (int'(shamt) >= WIDTH);

  always_comb begin
    sc_result = a_in;
    sc_carry  = 1'b0;
    sum_w     = '0;
    case (op)
      OP_ADD: begin
        sum_w     = {1'b0, a_in} + {1'b0, b_val};
        sc_result = sum_w[WIDTH-1:0];
        sc_carry  = sum_w[WIDTH];
      end
      OP_SUB: begin
        sum_w     = {1'b0, a_in} - {1'b0, b_val};
        sc_result = sum_w[WIDTH-1:0];
        sc_carry  = sum_w[WIDTH];
      end
      OP_AND:  sc_result = a_in & b_val;
      OP_NAND: sc_result = ~(a_in & b_val);
      OP_OR:   sc_result = a_in | b_val;
      OP_NOR:  sc_result = ~(a_in | b_val);
      OP_XOR:  sc_result = a_in ^ b_val;
      OP_XNOR: sc_result = ~(a_in ^ b_val);
      OP_SHL:  sc_result = shamt_big ? '0 : (a_in << shamt);
      OP_SHR:  sc_result = shamt_big ? '0 : (a_in >> shamt);
      OP_CLR:  sc_result = '0;
      default: sc_result = a_in;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .is_div (op == OP_DIV),
    .a      (a_in),
    .b      (b_val),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result),
    .flag   (md_flag)
  );

  // Result, flags and acc only change on the edge that enters DONE, so they hold during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      we_q   <= 1'b0;
      result <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      acc    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            we_q <= acc_we;
            if (is_iter(op)) begin
              state <= ST_EXEC;
            end else begin
              state  <= ST_DONE;
              result <= sc_result;
              flag_c <= sc_carry;
              flag_z <= (sc_result == '0);
              flag_v <= 1'b0;
              if (acc_we || (op == OP_CLR)) acc <= sc_result;
            end
          end
        end
        ST_EXEC: begin
          if (md_done) begin
            state  <= ST_DONE;
            result <= md_result;
            flag_c <= 1'b0;
            flag_z <= (md_result == '0);
            flag_v <= md_flag;
            if (we_q) acc <= md_result;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_acc_seq.sv
// Self-checking bench for alu_acc_seq (WIDTH=16): vector table, scoreboard queue, corner sequences.
module tb_alu_acc_seq;
  import alu_pkg::*;

  localparam int W  = 16;
  localparam int EW = 2 * W + 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'd0;
  logic [1:0]   b_sel = 2'd0;
  logic         acc_we = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         flag_c;
  logic         flag_z;
  logic         flag_v;
  logic [W-1:0] acc;

  alu_acc_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .b_sel     (b_sel),
    .acc_we    (acc_we),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_v    (flag_v),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [1:0]   bsel;
    logic         we;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    int           lat;
    bit           poke;
  } vec_t;

  vec_t           vecs[$];
  logic [EW-1:0]  exp_q[$];
  logic [W-1:0]   acc_m = '0;
  int             n_vec = 0;
  int             n_miss = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic [W-1:0] r, input logic c, input logic v,
                                         input logic [W-1:0] ac);
    return {r, c, (r == '0), v, ac};
  endfunction

  // Issues one command, checks latency and the popped expectation, optionally stalls out_ready.
  task automatic run_cmd(input logic [3:0] o, input logic [1:0] bs, input logic we,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [EW-1:0] expv, input int exp_lat,
                         input int stall, input bit poke);
    int t;
    logic [EW-1:0] e;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) cmp("in_ready_timeout", 32'(t), 32'd0);
    op = o; b_sel = bs; acc_we = we; a_in = a; b_in = b;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    exp_q.push_back(expv);
    @(negedge clk);
    in_valid = 1'b0;
    op = 4'($urandom_range(0, 15));
    b_sel = 2'($urandom_range(0, 3));
    acc_we = 1'($urandom_range(0, 1));
    a_in = 16'($urandom);
    b_in = 16'($urandom);
    t = 1;
    while (!out_valid && t < 60) begin
      in_valid = poke && (t >= 2) && (t <= 5);
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0;
    cmp("latency", 32'(t), 32'(exp_lat));
    if (exp_q.size() == 0) begin
      cmp("scoreboard_empty", 32'd0, 32'd1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    cmp("result", 32'(result), 32'(e[EW-1:W+3]));
    cmp("flag_c", 32'(flag_c), 32'(e[W+2]));
    cmp("flag_z", 32'(flag_z), 32'(e[W+1]));
    cmp("flag_v", 32'(flag_v), 32'(e[W]));
    cmp("acc", 32'(acc), 32'(e[W-1:0]));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      cmp("stall_result", 32'(result), 32'(e[EW-1:W+3]));
      cmp("stall_flags", 32'({flag_c, flag_z, flag_v}), 32'(e[W+2:W]));
      cmp("stall_out_valid", 32'(out_valid), 32'd1);
      cmp("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    cmp("handshake_idle", 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [W-1:0] ea;

    vecs.push_back('{OP_ADD,  BSEL_B,    1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1,  1'b0});
    vecs.push_back('{OP_ADD,  BSEL_B,    1'b1, 16'd5,    16'd3,    16'd8,    1'b0, 1'b0, 1,  1'b0});
    vecs.push_back('{OP_ADD,  BSEL_ACC,  1'b1, 16'd10,   16'hDEAD, 16'd18,   1'b0, 1'b0, 1,  1'b0});
    vecs.push_back('{OP_SUB,  BSEL_B,    1'b0, 16'd3,    16'd5,    16'hFFFE, 1'b1, 1'b0, 1,  1'b0});
    vecs.push_back('{OP_SUB,  BSEL_B,    1'b0, 16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1,  1'b0});
    vecs.push_back('{OP_AND,  BSEL_B,    1'b0, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1,  1'b0});
    vecs.push_back('{OP_NAND, BSEL_B,    1'b0, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0, 1'b0, 1,  1'b0});
    vecs.push_back('{OP_OR,   BSEL_B,    1'b0, 16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0, 1'b0, 1,  1'b0});
    vecs.push_back('{OP_NOR,  BSEL_B,    1'b0, 16'hF0F0, 16'h0F00, 16'h000F, 1'b0, 1'b0, 1,  1'b0});
    vecs.push_back('{OP_XOR,  BSEL_B,    1'b0, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0, 1'b0, 1,  1'b0});
    vecs.push_back('{OP_XNOR, BSEL_B,    1'b0, 16'hAAAA, 16'hAAAA, 16'hFFFF, 1'b0, 1'b0, 1,  1'b0});
    vecs.push_back('{OP_SHL,  BSEL_B,    1'b0, 16'h0003, 16'd4,    16'h0030, 1'b0, 1'b0, 1,  1'b0});
    vecs.push_back('{OP_SHR,  BSEL_B,    1'b0, 16'h8000, 16'd16,   16'h0000, 1'b0, 1'b0, 1,  1'b0});
    vecs.push_back('{OP_SHR,  BSEL_B,    1'b0, 16'h8000, 16'd15,   16'h0001, 1'b0, 1'b0, 1,  1'b0});
    vecs.push_back('{OP_SHL,  BSEL_B,    1'b0, 16'h0001, 16'h0020, 16'h0001, 1'b0, 1'b0, 1,  1'b0});
    vecs.push_back('{OP_SHL,  BSEL_B,    1'b0, 16'hFFFF, 16'd31,   16'h0000, 1'b0, 1'b0, 1,  1'b0});
    vecs.push_back('{OP_MUL,  BSEL_B,    1'b1, 16'd300,  16'd300,  16'h5F90, 1'b0, 1'b1, 17, 1'b1});
    vecs.push_back('{OP_MUL,  BSEL_B,    1'b0, 16'd255,  16'd257,  16'hFFFF, 1'b0, 1'b0, 17, 1'b0});
    vecs.push_back('{OP_DIV,  BSEL_B,    1'b0, 16'd1000, 16'd7,    16'd142,  1'b0, 1'b0, 17, 1'b1});
    vecs.push_back('{OP_DIV,  BSEL_B,    1'b0, 16'd1000, 16'd0,    16'hFFFF, 1'b0, 1'b1, 17, 1'b0});
    vecs.push_back('{OP_DIV,  BSEL_B,    1'b0, 16'd5,    16'd9,    16'h0000, 1'b0, 1'b0, 17, 1'b0});
    vecs.push_back('{OP_PASS, BSEL_ZERO, 1'b1, 16'h1234, 16'h5678, 16'h1234, 1'b0, 1'b0, 1,  1'b0});
    vecs.push_back('{4'd15,   BSEL_B,    1'b0, 16'hBEEF, 16'h0001, 16'hBEEF, 1'b0, 1'b0, 1,  1'b0});
    vecs.push_back('{OP_ADD,  BSEL_ZERO, 1'b0, 16'd7,    16'd100,  16'd7,    1'b0, 1'b0, 1,  1'b0});
    vecs.push_back('{OP_ADD,  BSEL_RSVD, 1'b0, 16'd7,    16'd100,  16'd7,    1'b0, 1'b0, 1,  1'b0});
    vecs.push_back('{OP_MUL,  BSEL_ACC,  1'b1, 16'd2,    16'h0007, 16'h2468, 1'b0, 1'b0, 17, 1'b0});
    vecs.push_back('{OP_CLR,  BSEL_B,    1'b0, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b0, 1,  1'b0});
    vecs.push_back('{OP_SUB,  BSEL_B,    1'b0, 16'd0,    16'd0,    16'h0000, 1'b0, 1'b0, 1,  1'b0});

    // Clock/reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp("reset_in_ready", 32'(in_ready), 32'd1);
    cmp("reset_out_valid", 32'(out_valid), 32'd0);
    cmp("reset_result", 32'(result), 32'd0);
    cmp("reset_flags", 32'({flag_c, flag_z, flag_v}), 32'd0);
    cmp("reset_acc", 32'(acc), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      ea = (v.we || v.op == OP_CLR) ? v.r : acc_m;
      run_cmd(v.op, v.bsel, v.we, v.a, v.b, pack(v.r, v.c, v.v, ea), v.lat, 0, v.poke);
      acc_m = ea;
    end

    // Consumer stall: outputs hold and no new command is accepted.
    run_cmd(OP_SHL, BSEL_B, 1'b0, 16'h0003, 16'd4, pack(16'h0030, 1'b0, 1'b0, acc_m), 1, 3, 1'b0);
    run_cmd(OP_SHR, BSEL_B, 1'b0, 16'h8000, 16'd16, pack(16'h0000, 1'b0, 1'b0, acc_m), 1, 3, 1'b0);

    // Reset in the middle of a multiply aborts it without touching acc.
    run_cmd(OP_PASS, BSEL_B, 1'b1, 16'h55AA, 16'h0000, pack(16'h55AA, 1'b0, 1'b0, 16'h55AA), 1, 0, 1'b0);
    acc_m = 16'h55AA;
    op = OP_MUL; b_sel = BSEL_B; acc_we = 1'b1; a_in = 16'd300; b_in = 16'd300;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acc_m = '0;
    cmp("midmul_rst_out_valid", 32'(out_valid), 32'd0);
    cmp("midmul_rst_in_ready", 32'(in_ready), 32'd1);
    cmp("midmul_rst_acc", 32'(acc), 32'(acc_m));
    cmp("midmul_rst_result", 32'(result), 32'd0);
    cmp("midmul_rst_flags", 32'({flag_c, flag_z, flag_v}), 32'd0);
    repeat (20) @(negedge clk);
    cmp("midmul_no_stale_done", 32'({out_valid, in_ready}), 32'b01);
    cmp("midmul_acc_after", 32'(acc), 32'(acc_m));

    run_cmd(OP_ADD, BSEL_B, 1'b1, 16'd1, 16'd1, pack(16'd2, 1'b0, 1'b0, 16'd2), 1, 0, 1'b0);
    acc_m = 16'd2;

    cmp("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
